// File: rtl/ioctl_sender.sv
// ioctl_sender: initiator side of the ioctl download protocol.
// Fetches bytes from a synchronous source memory (data valid one cycle after
// src_rd) and presents them to a core as ioctl_wr/ioctl_addr/ioctl_dout
// writes, honouring ioctl_wait back-pressure.
// Optional feature macro: IOCTL_SENDER_CKSUM_EN (8-bit running sum of written bytes on cksum).
module ioctl_sender #(
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned WR_GAP    = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        index,
  input  logic [ADDR_W-1:0] length,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic              ioctl_download,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_index,
  input  logic              ioctl_wait,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [7:0]        cksum
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(WR_GAP);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    FETCH = 3'd2,
    LATCH = 3'd3,
    READY = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic [ADDR_W-1:0]   length_q, length_d;
  logic [7:0]          index_q, index_d;
  logic                download_q, download_d;
  logic                busy_q, busy_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          dout_q, dout_d;
  logic                src_rd_q, src_rd_d;
  logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;

  // Start is refused in the completion cycle so a back-to-back request cannot overlap done.
  logic accept_c;
  assign accept_c = (state_q == IDLE) && start && !abort && !done_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    offset_d   = offset_q;
    length_d   = length_q;
    index_d    = index_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    wr_d       = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    if (state_q != IDLE && abort) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            index_d  = index;
            length_d = length;
            offset_d = '0;
            cnt_d    = '0;
            state_d  = SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            if (length_q == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = FETCH;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FETCH: begin
          state_d = LATCH;
        end
        LATCH: begin
          dout_d  = src_data;
          addr_d  = offset_q;
          state_d = READY;
        end
        READY: begin
          if (!ioctl_wait) begin
            wr_d     = 1'b1;
            offset_d = offset_q + ADDR_W'(1);
            cnt_d    = '0;
            state_d  = GAP;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            if (offset_q < length_q) begin
              state_d = FETCH;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Status outputs follow the state being entered so they line up with it.
    download_d = (state_d != IDLE);
    busy_d     = (state_d != IDLE);
    src_rd_d   = (state_d == FETCH);
    src_addr_d = (state_d == FETCH) ? offset_d : src_addr_q;
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      offset_q   <= '0;
      length_q   <= '0;
      index_q    <= '0;
      download_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      src_rd_q   <= 1'b0;
      src_addr_q <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      offset_q   <= offset_d;
      length_q   <= length_d;
      index_q    <= index_d;
      download_q <= download_d;
      busy_q     <= busy_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      src_rd_q   <= src_rd_d;
      src_addr_q <= src_addr_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

`ifdef IOCTL_SENDER_CKSUM_EN
  logic [7:0] cksum_q, cksum_d;

  // Running sum of bytes written; dout_q is stable when the write is issued.
  always_comb begin
    cksum_d = cksum_q;
    if (accept_c) begin
      cksum_d = '0;
    end else if (wr_d) begin
      cksum_d = cksum_q + dout_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign cksum = cksum_q;
`else
  assign cksum = 8'h00;
`endif

  assign src_rd         = src_rd_q;
  assign src_addr       = src_addr_q;
  assign ioctl_download = download_q;
  assign ioctl_wr       = wr_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign ioctl_index    = index_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;

endmodule
